// File: rtl/uart_tx_periph.sv
// -----------------------------------------------------------------------------
// uart_tx_periph
//
// Memory-mapped 8N1 UART transmitter that sits on the CPU data bus beside the
// data RAM and the GPIO register. Stored bytes are queued in a small FIFO and
// shifted out LSB first on tx. Read data is registered and is zero whenever
// no selected load was sampled, so the top level can OR it with other sources.
//
// Register map (index = data_addr[3:2], page = data_addr[31:10]):
//   0 TXDATA  W   byte lane 0 pushed into the FIFO (dropped + sticky overflow if full)
//   1 STATUS  R/W bit0 busy, bit1 full, bit2 empty, bit3 overflow, [7:4] count;
//                 writing lane 0 with bit3 set clears overflow
//   2 DIV     R/W 16-bit clocks-per-bit divisor (0 behaves as 1)
//   3 -       reads 0, writes ignored
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   data_addr   CPU data address
//   datamem_rd  CPU load strobe
//   datamem_wr  CPU store byte strobes (bit n qualifies data_wrn)
//   data_wr0..3 store data byte lanes (lanes 2 and 3 unused)
//   data_rd     registered read data
//   tx          serial output, idle high
//   tx_busy     FSM not idle or FIFO not empty
// -----------------------------------------------------------------------------
module uart_tx_periph #(
    parameter int unsigned BASE_PAGE  = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_addr,
    input  logic        datamem_rd,
    input  logic [3:0]  datamem_wr,
    input  logic [7:0]  data_wr0,
    input  logic [7:0]  data_wr1,
    input  logic [7:0]  data_wr2,
    input  logic [7:0]  data_wr3,
    output logic [31:0] data_rd,
    output logic        tx,
    output logic        tx_busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam logic [1:0] IDX_TXDATA = 2'd0;
    localparam logic [1:0] IDX_STATUS = 2'd1;
    localparam logic [1:0] IDX_DIV    = 2'd2;

    // ---------------------------------------------------------------- state
    logic [1:0]       state_q,    state_d;
    logic [7:0]       shift_q,    shift_d;
    logic [2:0]       bit_q,      bit_d;
    logic [15:0]      baud_q,     baud_d;
    logic             tx_q,       tx_d;
    logic [15:0]      div_q,      div_d;
    logic             overflow_q, overflow_d;
    logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [CNT_W-1:0] count_q,    count_d;
    logic [31:0]      rd_q,       rd_d;
    logic [7:0]       fifo_q [FIFO_DEPTH];

    // ---------------------------------------------------------------- decode
    logic       sel;
    logic [1:0] idx;
    logic       wr_lane0;
    logic       push_req;
    logic       push;
    logic       pop;
    logic       full;
    logic       empty;
    logic [15:0] div_eff;
    logic       bit_end;
    logic [7:0] count_ext;
    logic [7:0] status;

    assign sel      = (data_addr[31:10] == 22'(BASE_PAGE));
    assign idx      = data_addr[3:2];
    assign wr_lane0 = sel && datamem_wr[0];
    assign push_req = wr_lane0 && (idx == IDX_TXDATA);

    assign full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty = (count_q == '0);

    // A byte popped in the same edge frees a slot, so a full FIFO still
    // accepts a store that coincides with the FSM pop.
    assign push = push_req && (!full || pop);

    // Divisor 0 would never end a bit; it behaves as 1.
    assign div_eff = (div_q == 16'd0) ? 16'd1 : div_q;
    // Compare with >= so that lowering DIV below the current count ends the
    // bit at once instead of waiting for a 16-bit wrap.
    assign bit_end = (baud_q >= (div_eff - 16'd1));

    assign count_ext = {{(8 - CNT_W){1'b0}}, count_q};
    assign status    = {count_ext[3:0], overflow_q, empty, full, (state_q != S_IDLE)};

    // ---------------------------------------------------------------- FSM
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        baud_d  = baud_q;
        pop     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_q[rd_ptr_q];
                    baud_d  = 16'd0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    baud_d  = 16'd0;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_d  = 16'd0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    baud_d  = 16'd0;
                    state_d = S_IDLE;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // tx is registered from the next state so the line changes on the
        // same edge the FSM does.
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // ---------------------------------------------------------------- FIFO / registers
    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        div_d      = div_q;

        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        if (push_req && !push) begin
            overflow_d = 1'b1;
        end else if (wr_lane0 && (idx == IDX_STATUS) && data_wr0[3]) begin
            overflow_d = 1'b0;
        end

        if (sel && (idx == IDX_DIV)) begin
            if (datamem_wr[0]) div_d[7:0]  = data_wr0;
            if (datamem_wr[1]) div_d[15:8] = data_wr1;
        end
    end

    // ---------------------------------------------------------------- read path
    always_comb begin
        rd_d = 32'd0;
        if (datamem_rd && sel) begin
            case (idx)
                IDX_STATUS: rd_d = {24'd0, status};
                IDX_DIV:    rd_d = {16'd0, div_q};
                default:    rd_d = 32'd0;
            endcase
        end
    end

    // ---------------------------------------------------------------- sequential
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (rst) begin
            state_q    <= S_IDLE;
            shift_q    <= 8'd0;
            bit_q      <= 3'd0;
            baud_q     <= 16'd0;
            tx_q       <= 1'b1;
            div_q      <= DIV_RESET;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_q       <= 32'd0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_q      <= bit_d;
            baud_q     <= baud_d;
            tx_q       <= tx_d;
            div_q      <= div_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_q       <= rd_d;
        end
    end

    // NOTE: the FIFO storage has no reset; the count and pointers alone decide
    // which entries are valid, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= data_wr0;
        end
    end

    assign data_rd = rd_q;
    assign tx      = tx_q;
    assign tx_busy = (state_q != S_IDLE) || !empty;

    // Byte lanes 2/3, the aliased address bits and the upper count bits carry
    // no function in this block.
    logic unused_bits;
    assign unused_bits = ^{data_wr2, data_wr3, data_addr[9:4], data_addr[1:0],
                           datamem_wr[3:2], count_ext[7:4]};

endmodule

// File: tb/tb_uart_tx_periph.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_periph
//
// Directed bench for uart_tx_periph. A behavioural model tracks the FIFO as a
// list of bytes and the transmitter as "frame active, cycles elapsed, byte";
// the line level is derived from elapsed/DIV as the frame bit index. A compare
// process checks tx, tx_busy and data_rd against the model every cycle, and
// the directed sequence pins the model with hand-computed literals.
// -----------------------------------------------------------------------------
module tb_uart_tx_periph;

    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_0800;  // page 2

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data_addr  = 32'd0;
    logic        datamem_rd = 1'b0;
    logic [3:0]  datamem_wr = 4'd0;
    logic [7:0]  data_wr0   = 8'd0;
    logic [7:0]  data_wr1   = 8'd0;
    logic [7:0]  data_wr2   = 8'hFF;
    logic [7:0]  data_wr3   = 8'hFF;
    logic [31:0] data_rd;
    logic        tx;
    logic        tx_busy;

    uart_tx_periph #(
        .BASE_PAGE (2),
        .FIFO_DEPTH(DEPTH),
        .DIV_RESET (16'd434)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_addr (data_addr),
        .datamem_rd(datamem_rd),
        .datamem_wr(datamem_wr),
        .data_wr0  (data_wr0),
        .data_wr1  (data_wr1),
        .data_wr2  (data_wr2),
        .data_wr3  (data_wr3),
        .data_rd   (data_rd),
        .tx        (tx),
        .tx_busy   (tx_busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int div_eff(input logic [15:0] d);
        return (d == 16'd0) ? 1 : int'(d);
    endfunction

    // ---------------------------------------------------------------- model
    logic [7:0]  m_buf [16];   // m_buf[0] is the oldest queued byte
    int          m_cnt = 0;
    logic        m_act = 1'b0;
    int          m_cyc = 0;
    logic [7:0]  m_byte = 8'd0;
    logic        m_ovf = 1'b0;
    logic [15:0] m_div = 16'd434;
    logic [31:0] m_rd = 32'd0;

    always @(posedge clk) begin : model
        logic [7:0]  nb [16];
        int          ncnt;
        logic        nact;
        int          ncyc;
        logic [7:0]  nbyte;
        logic        novf;
        logic [15:0] ndiv;
        logic [31:0] nrd;
        logic        msel;
        logic [1:0]  midx;

        nb = m_buf; ncnt = m_cnt; nact = m_act; ncyc = m_cyc;
        nbyte = m_byte; novf = m_ovf; ndiv = m_div; nrd = 32'd0;
        msel = (data_addr[31:10] == 22'd2);
        midx = data_addr[3:2];

        if (rst) begin
            ncnt = 0; nact = 1'b0; ncyc = 0; novf = 1'b0; ndiv = 16'd434;
        end else begin
            if (datamem_rd && msel) begin
                if (midx == 2'd1)
                    nrd = {24'd0, 4'(m_cnt), m_ovf, (m_cnt == 0), (m_cnt == DEPTH), m_act};
                else if (midx == 2'd2)
                    nrd = {16'd0, m_div};
            end
            // A frame lasts 10 bit times; the edge after it is idle, and an
            // idle edge with a queued byte starts the next frame.
            if (m_act) begin
                ncyc = m_cyc + 1;
                if (ncyc >= 10 * div_eff(m_div)) nact = 1'b0;
            end else if (m_cnt > 0) begin
                nbyte = nb[0];
                for (int i = 0; i < 15; i++) nb[i] = nb[i + 1];
                ncnt = ncnt - 1;
                nact = 1'b1;
                ncyc = 0;
            end
            if (msel && datamem_wr[0] && midx == 2'd0) begin
                if (ncnt < DEPTH) begin
                    nb[ncnt] = data_wr0;
                    ncnt = ncnt + 1;
                end else begin
                    novf = 1'b1;
                end
            end
            if (msel && datamem_wr[0] && midx == 2'd1 && data_wr0[3]) novf = 1'b0;
            if (msel && midx == 2'd2) begin
                if (datamem_wr[0]) ndiv[7:0]  = data_wr0;
                if (datamem_wr[1]) ndiv[15:8] = data_wr1;
            end
        end

        m_buf <= nb; m_cnt <= ncnt; m_act <= nact; m_cyc <= ncyc;
        m_byte <= nbyte; m_ovf <= novf; m_div <= ndiv; m_rd <= nrd;
    end

    // ---------------------------------------------------------------- compare
    always @(negedge clk) begin : compare
        logic exp_tx;
        int   b;
        if (chk_en) begin
            if (!m_act) begin
                exp_tx = 1'b1;
            end else begin
                b = m_cyc / div_eff(m_div);
                if (b == 0)      exp_tx = 1'b0;
                else if (b >= 9) exp_tx = 1'b1;
                else             exp_tx = m_byte[b - 1];
            end
            check("tx", 32'(tx), 32'(exp_tx));
            check("tx_busy", 32'(tx_busy), 32'(m_act || (m_cnt != 0)));
            check("data_rd", data_rd, m_rd);
        end
    end

    // ---------------------------------------------------------------- bus tasks
    task automatic bus_write(input logic [31:0] a, input logic [3:0] s,
                             input logic [7:0] b0, input logic [7:0] b1);
        data_addr = a; datamem_wr = s; data_wr0 = b0; data_wr1 = b1;
        @(negedge clk);
        data_addr = 32'd0; datamem_wr = 4'd0; data_wr0 = 8'd0; data_wr1 = 8'd0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] v);
        data_addr = a; datamem_rd = 1'b1;
        @(negedge clk);
        v = data_rd;
        data_addr = 32'd0; datamem_rd = 1'b0;
    endtask

    // ---------------------------------------------------------------- sequence
    initial begin : main
        logic [31:0] v;
        logic        pat [10];
        int          g;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        // Reset state
        check("rst_tx", 32'(tx), 32'd1);
        bus_read(BASE + 32'h4, v);   check("rst_status", v, 32'h0000_0004);
        bus_read(BASE + 32'h8, v);   check("rst_div", v, 32'd434);
        bus_read(BASE + 32'h3F4, v); check("alias_status", v, 32'h0000_0004);

        // DIV=4, one byte 0xA5: start, 1,0,1,0,0,1,0,1, stop at 4 cycles each
        bus_write(BASE + 32'h8, 4'b0011, 8'h04, 8'h00);
        bus_write(BASE + 32'h0, 4'b0001, 8'hA5, 8'h00);
        check("a5_store_tx_idle", 32'(tx), 32'd1);
        check("a5_store_busy", 32'(tx_busy), 32'd1);
        pat = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            check($sformatf("a5_frame_bit%0d", (k - 1) / 4), 32'(tx), 32'(pat[(k - 1) / 4]));
        end
        check("a5_busy_at_40", 32'(tx_busy), 32'd1);
        @(negedge clk);
        check("a5_busy_fall", 32'(tx_busy), 32'd0);

        // DIV=2, six back-to-back stores: 0x01 popped at once, 0x02..0x05
        // fill the FIFO, 0x06 overflows
        bus_write(BASE + 32'h8, 4'b0011, 8'h02, 8'h00);
        for (int i = 1; i <= 6; i++) bus_write(BASE, 4'b0001, 8'(i), 8'h00);
        bus_read(BASE + 32'h4, v);  check("burst_status", v, 32'h0000_004B);
        bus_write(BASE + 32'h4, 4'b0001, 8'h08, 8'h00);
        bus_read(BASE + 32'h4, v);  check("ovf_cleared_status", v, 32'h0000_0043);

        // Store on the edge the FSM pops from a full FIFO
        g = 0;
        while (!(!m_act && m_cnt == DEPTH) && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("full_idle_reached", 32'(g < 200), 32'd1);
        bus_write(BASE, 4'b0001, 8'h07, 8'h00);
        bus_read(BASE + 32'h4, v);  check("pushpop_status", v, 32'h0000_0043);

        // Drain the remaining frames
        g = 0;
        while ((m_act || m_cnt != 0) && g < 3000) begin
            @(negedge clk);
            g++;
        end
        check("drain_done", 32'(g < 3000), 32'd1);
        check("drained_busy", 32'(tx_busy), 32'd0);
        check("drained_tx", 32'(tx), 32'd1);

        // DIV=0 behaves as 1: a 10-cycle frame
        bus_write(BASE + 32'h8, 4'b0011, 8'h00, 8'h00);
        bus_read(BASE + 32'h8, v);  check("div0_readback", v, 32'd0);
        bus_write(BASE, 4'b0001, 8'h5A, 8'h00);
        repeat (10) @(negedge clk);
        check("div0_busy_at_10", 32'(tx_busy), 32'd1);
        @(negedge clk);
        check("div0_busy_fall", 32'(tx_busy), 32'd0);

        // Reset in the middle of a data bit
        bus_write(BASE + 32'h8, 4'b0011, 8'h02, 8'h00);
        bus_write(BASE, 4'b0001, 8'hC3, 8'h00);
        repeat (6) @(negedge clk);
        check("pre_reset_busy", 32'(tx_busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_reset_tx", 32'(tx), 32'd1);
        check("mid_reset_busy", 32'(tx_busy), 32'd0);
        bus_read(BASE + 32'h4, v);  check("mid_reset_status", v, 32'h0000_0004);
        bus_read(BASE + 32'h8, v);  check("mid_reset_div", v, 32'd434);

        // Unselected pages have no effect
        bus_write(32'h0000_0400, 4'b0001, 8'h11, 8'h00);
        bus_write(32'h0000_0000, 4'b0001, 8'h22, 8'h00);
        bus_write(32'h0000_0408, 4'b0011, 8'h09, 8'h00);
        check("unsel_busy", 32'(tx_busy), 32'd0);
        bus_read(BASE + 32'h4, v);        check("unsel_status", v, 32'h0000_0004);
        bus_read(BASE + 32'h8, v);        check("unsel_div", v, 32'd434);
        bus_read(32'h0000_0404, v);       check("unsel_load_status", v, 32'd0);
        bus_read(32'h0000_0008, v);       check("unsel_load_div", v, 32'd0);
        bus_read(BASE + 32'hC, v);        check("idx3_read", v, 32'd0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, n_vec=%0d n_mis=%0d", n_vec, n_mis);
        $fatal(1);
    end

endmodule
